axil_mul_slave: RTL and testbench

AXIL_MUL_SLAVE -- requirements
Module: axil_mul_slave

---
 rtl/axil_mul_pkg.sv | 26 ++
 rtl/axil_mul_slave_seq_mul.sv | 84 ++++++++
 rtl/axil_mul_slave.sv | 169 ++++++++++++++++
 tb/tb_axil_mul_slave.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_mul_pkg.sv
// Shared constants for the AXI4-Lite multiplier slave: register map, bit positions,
// response codes and the multiplier FSM state type.
package axil_mul_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_STATUS   = 1;
  localparam int unsigned REG_OP_A     = 2;
  localparam int unsigned REG_OP_B     = 3;
  localparam int unsigned REG_RES_LO   = 4;
  localparam int unsigned REG_RES_HI   = 5;
  localparam int unsigned REG_SCRATCH0 = 6;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/axil_mul_slave_seq_mul.sv
// Unsigned radix-2 shift-add multiplier: one multiplier bit per cycle.
module seq_mul
  import axil_mul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CNT_W = $clog2(W) + 1;

  mul_state_t       state, state_nxt;
  logic [2*W-1:0]   mcand;
  logic [2*W-1:0]   acc;
  logic [W-1:0]     mplier;
  logic [CNT_W-1:0] cnt;
  logic             last_step;

  assign last_step = (cnt == CNT_W'(W - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for W steps, DONE for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !busy) state_nxt = ST_RUN;
      ST_RUN:  if (last_step)      state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath. busy stays high through the cycle where the done pulse is seen by
  // the register block, so busy clears and done sets on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !busy) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        ST_DONE: begin
          product <= acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axil_mul_slave.sv
// AXI4-Lite register slave fronting a sequential shift-add multiplier.
module axil_mul_slave
  import axil_mul_pkg::*;
#(
  parameter  int C_S_AXI_DATA_WIDTH = 32,
  parameter  int C_NUM_REGS         = 8,
  localparam int C_S_AXI_ADDR_WIDTH = $clog2(C_NUM_REGS) + 2
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic                              irq
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IDX_W = AW - 2;

  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(REG_CTRL);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(REG_STATUS);
  localparam logic [IDX_W-1:0] IDX_OP_A   = IDX_W'(REG_OP_A);
  localparam logic [IDX_W-1:0] IDX_OP_B   = IDX_W'(REG_OP_B);
  localparam logic [IDX_W-1:0] IDX_RES_LO = IDX_W'(REG_RES_LO);
  localparam logic [IDX_W-1:0] IDX_RES_HI = IDX_W'(REG_RES_HI);

  logic             wr_hs, rd_hs;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DW-1:0]    wmask, rd_word;
  logic             irq_en, st_done;
  logic [DW-1:0]    op_a, op_b, res_lo, res_hi;
  logic [DW-1:0]    scratch [REG_SCRATCH0:C_NUM_REGS-1];
  logic             start_go, done_w1c;
  logic             mul_busy, mul_done;
  logic [2*DW-1:0]  mul_product;
  logic             unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_idx = s_axi_awaddr[AW-1:2];
  assign rd_idx = s_axi_araddr[AW-1:2];

  assign wr_hs = s_axi_aresetn && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
  assign rd_hs = s_axi_aresetn && s_axi_arvalid && !s_axi_rvalid;

  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_arready = rd_hs;
  assign s_axi_bresp   = AXI_RESP_OKAY;
  assign s_axi_rresp   = AXI_RESP_OKAY;

  assign start_go = wr_hs && (wr_idx == IDX_CTRL) && s_axi_wstrb[0]
                    && s_axi_wdata[CTRL_START_BIT] && !mul_busy;
  assign done_w1c = wr_hs && (wr_idx == IDX_STATUS) && s_axi_wstrb[0]
                    && s_axi_wdata[STATUS_DONE_BIT];

  assign irq = st_done && irq_en;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [DW-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Byte-lane write mask from wstrb.
  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < DW / 8; i++) wmask[8*i +: 8] = {8{s_axi_wstrb[i]}};
  end

  // Register file writes, result capture and sticky done (set beats clear).
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      irq_en  <= 1'b0;
      st_done <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      res_lo  <= '0;
      res_hi  <= '0;
      for (int unsigned i = REG_SCRATCH0; i < C_NUM_REGS; i++) scratch[i] <= '0;
    end else begin
      if (wr_hs) begin
        case (wr_idx)
          IDX_CTRL:   if (s_axi_wstrb[0]) irq_en <= s_axi_wdata[CTRL_IRQ_EN_BIT];
          IDX_STATUS, IDX_RES_LO, IDX_RES_HI: ;
          IDX_OP_A:   op_a <= merge(op_a, s_axi_wdata, wmask);
          IDX_OP_B:   op_b <= merge(op_b, s_axi_wdata, wmask);
          default: begin
            for (int unsigned i = REG_SCRATCH0; i < C_NUM_REGS; i++)
              if (wr_idx == IDX_W'(i)) scratch[i] <= merge(scratch[i], s_axi_wdata, wmask);
          end
        endcase
      end
      if (mul_done) begin
        res_lo <= mul_product[DW-1:0];
        res_hi <= mul_product[2*DW-1:DW];
      end
      if (mul_done)                  st_done <= 1'b1;
      else if (start_go || done_w1c) st_done <= 1'b0;
    end
  end

  // Read data mux.
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      IDX_CTRL:   rd_word[CTRL_IRQ_EN_BIT] = irq_en;
      IDX_STATUS: begin
        rd_word[STATUS_BUSY_BIT] = mul_busy;
        rd_word[STATUS_DONE_BIT] = st_done;
      end
      IDX_OP_A:   rd_word = op_a;
      IDX_OP_B:   rd_word = op_b;
      IDX_RES_LO: rd_word = res_lo;
      IDX_RES_HI: rd_word = res_hi;
      default: begin
        for (int unsigned i = REG_SCRATCH0; i < C_NUM_REGS; i++)
          if (rd_idx == IDX_W'(i)) rd_word = scratch[i];
      end
    endcase
  end

  // B and R channel valid/data holding until the master accepts.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_bvalid <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
    end else begin
      if (wr_hs)             s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_word;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  seq_mul #(.W(DW)) u_mul (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .start   (start_go),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_axil_mul_slave.sv
// Testbench for axil_mul_slave: register table, randomized multiplies against an
// arithmetic model, busy/restart/reset corner sequences and channel backpressure.
module tb_axil_mul_slave;

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] A_OPA    = 5'h08;
  localparam logic [4:0] A_OPB    = 5'h0C;
  localparam logic [4:0] A_RLO    = 5'h10;
  localparam logic [4:0] A_RHI    = 5'h14;
  localparam logic [4:0] A_S6     = 5'h18;
  localparam logic [4:0] A_S7     = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        irq;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  axil_mul_slave #(.C_S_AXI_DATA_WIDTH(32), .C_NUM_REGS(8)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .irq           (irq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin checks++; failures++; $display("FAIL aw_timeout addr=0x%0h", addr); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; failures++; $display("FAIL b_timeout addr=0x%0h", addr); end
    chk("bresp", bresp, 2'b00);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin checks++; failures++; $display("FAIL ar_timeout addr=0x%0h", addr); end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; failures++; $display("FAIL r_timeout addr=0x%0h", addr); end
    data = rdata;
    chk("rresp", rresp, 2'b00);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Waits for irq; latency counted in clock edges from the start handshake edge,
  // given t0 = cycle count sampled just after the start write returned.
  task automatic wait_irq(input int unsigned t0, output int unsigned lat);
    int n;
    n = 0;
    while (!irq && n < 200) begin @(posedge clk); #1; n++; end
    if (!irq) begin checks++; failures++; $display("FAIL irq_timeout waited=%0d", n); end
    lat = cyc_cnt - t0 + 1;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [23];
  logic [31:0] d, held;
  logic [31:0] shadow [6:7];
  logic [31:0] opa_l [6];
  logic [31:0] opb_l [6];
  logic [63:0] model;
  int unsigned lat, t0, r;
  logic [31:0] rdat;
  logic [3:0]  rstb;

  initial begin
    vecs[0]  = '{1, A_S6,     32'hA5A5A5A5, 4'hF, 32'h0};
    vecs[1]  = '{1, A_S7,     32'h12345678, 4'hF, 32'h0};
    vecs[2]  = '{0, A_S6,     32'h0,        4'h0, 32'hA5A5A5A5};
    vecs[3]  = '{0, A_S7,     32'h0,        4'h0, 32'h12345678};
    vecs[4]  = '{1, A_S6,     32'hFFFFFFFF, 4'h2, 32'h0};
    vecs[5]  = '{0, A_S6,     32'h0,        4'h0, 32'hA5A5FFA5};
    vecs[6]  = '{1, A_RLO,    32'hDEADBEEF, 4'hF, 32'h0};
    vecs[7]  = '{0, A_RLO,    32'h0,        4'h0, 32'h0};
    vecs[8]  = '{1, A_RHI,    32'hDEADBEEF, 4'hF, 32'h0};
    vecs[9]  = '{0, A_RHI,    32'h0,        4'h0, 32'h0};
    vecs[10] = '{1, A_OPA,    32'h11223344, 4'h8, 32'h0};
    vecs[11] = '{0, A_OPA,    32'h0,        4'h0, 32'h11000000};
    vecs[12] = '{1, A_OPB,    32'h55667788, 4'h3, 32'h0};
    vecs[13] = '{0, A_OPB,    32'h0,        4'h0, 32'h00007788};
    vecs[14] = '{1, A_CTRL,   32'h000000FE, 4'h1, 32'h0};
    vecs[15] = '{0, A_CTRL,   32'h0,        4'h0, 32'h00000002};
    vecs[16] = '{1, A_STATUS, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[17] = '{0, A_STATUS, 32'h0,        4'h0, 32'h0};
    vecs[18] = '{1, A_CTRL,   32'h00000000, 4'hE, 32'h0};
    vecs[19] = '{0, A_CTRL,   32'h0,        4'h0, 32'h00000002};
    vecs[20] = '{1, A_CTRL,   32'h00000000, 4'hF, 32'h0};
    vecs[21] = '{0, A_CTRL,   32'h0,        4'h0, 32'h0};
    vecs[22] = '{0, 5'h1A,    32'h0,        4'h0, 32'hA5A5FFA5};

    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), d);
      chk($sformatf("rst_reg%0d", i), d, 32'h0);
    end

    // Register table.
    for (int i = 0; i < 23; i++) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else begin
        axi_read(vecs[i].addr, d);
        chk($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end

    // Backpressure with concurrent read and write.
    axi_write(A_S7, 32'h600DF00D, 4'hF);
    @(negedge clk);
    awaddr = A_S6; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = A_S7; arvalid = 1; bready = 0; rready = 0;
    #1;
    chk("bp_aw_accept", {awready, wready}, 2'b11);
    chk("bp_ar_accept", arready, 1'b1);
    @(posedge clk); #1;
    wdata = 32'h0BAD0BAD; araddr = A_S6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_bvalid", bvalid, 1'b1);
      chk("bp_rvalid", rvalid, 1'b1);
      chk("bp_rdata", rdata, 32'h600DF00D);
      chk("bp_no_aw", awready, 1'b0);
      chk("bp_no_ar", arready, 1'b0);
    end
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    chk("bp_bvalid_drop", bvalid, 1'b0);
    chk("bp_rvalid_drop", rvalid, 1'b0);
    axi_read(A_S6, d);
    chk("bp_s6_first_write", d, 32'hCAFEF00D);

    // Randomized scratch writes against a byte-merge shadow.
    axi_write(A_S6, 32'h0, 4'hF); shadow[6] = 32'h0;
    axi_write(A_S7, 32'h0, 4'hF); shadow[7] = 32'h0;
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(6, 7);
      rdat = $urandom;
      rstb = 4'($urandom_range(0, 15));
      axi_write(5'(r * 4), rdat, rstb);
      for (int b = 0; b < 4; b++) if (rstb[b]) shadow[r][8*b +: 8] = rdat[8*b +: 8];
      axi_read(5'(r * 4), d);
      chk("scratch_rand", d, shadow[r]);
    end

    // Multiplies checked against plain 64-bit arithmetic.
    opa_l[0] = 32'hFFFFFFFF; opb_l[0] = 32'hFFFFFFFF;
    opa_l[1] = 32'd3;        opb_l[1] = 32'd7;
    opa_l[2] = 32'd0;        opb_l[2] = $urandom;
    opa_l[3] = $urandom;     opb_l[3] = 32'h80000000;
    opa_l[4] = $urandom;     opb_l[4] = $urandom;
    opa_l[5] = $urandom;     opb_l[5] = $urandom;
    for (int k = 0; k < 6; k++) begin
      model = {32'h0, opa_l[k]} * {32'h0, opb_l[k]};
      axi_write(A_OPA, opa_l[k], 4'hF);
      axi_write(A_OPB, opb_l[k], 4'hF);
      axi_write(A_CTRL, 32'h3, 4'h1);
      t0 = cyc_cnt;
      chk("irq_low_after_start", irq, 1'b0);
      axi_read(A_STATUS, d);
      chk("status_busy", d, 32'h1);
      wait_irq(t0, lat);
      chk("latency", 64'(lat), 64'd34);
      axi_read(A_RLO, d);
      chk("result_lo", d, model[31:0]);
      axi_read(A_RHI, d);
      chk("result_hi", d, model[63:32]);
      axi_read(A_STATUS, d);
      chk("status_done", d, 32'h2);
      axi_write(A_STATUS, 32'h2, 4'h1);
      chk("irq_cleared", irq, 1'b0);
      axi_read(A_STATUS, d);
      chk("status_w1c", d, 32'h0);
    end

    // Operand rewrite and second start while busy.
    axi_write(A_OPA, 32'd5, 4'hF);
    axi_write(A_OPB, 32'd9, 4'hF);
    axi_write(A_CTRL, 32'h3, 4'h1);
    t0 = cyc_cnt;
    while (cyc_cnt - t0 < 9) @(posedge clk);
    #1;
    axi_write(A_OPA, 32'd0, 4'hF);
    axi_write(A_CTRL, 32'h3, 4'h1);
    axi_read(A_OPA, d);
    chk("busy_opa_updated", d, 32'h0);
    wait_irq(t0, lat);
    chk("busy_no_restart_latency", 64'(lat), 64'd34);
    axi_read(A_RLO, d);
    chk("busy_result_lo", d, 32'd45);
    axi_read(A_RHI, d);
    chk("busy_result_hi", d, 32'd0);
    axi_write(A_STATUS, 32'h2, 4'h1);

    // Reset pulse in the middle of a run.
    axi_write(A_OPA, 32'd100, 4'hF);
    axi_write(A_OPB, 32'd100, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'h1);
    repeat (5) @(posedge clk);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #2;
    chk("midrst_irq", irq, 1'b0);
    chk("midrst_bvalid", bvalid, 1'b0);
    #20;
    rst_n = 1'b1;
    axi_read(A_STATUS, d);
    chk("midrst_status", d, 32'h0);
    axi_read(A_RLO, d);
    chk("midrst_result_lo", d, 32'h0);
    axi_read(A_RHI, d);
    chk("midrst_result_hi", d, 32'h0);
    repeat (40) @(posedge clk);
    axi_read(A_STATUS, d);
    chk("midrst_status_late", d, 32'h0);
    axi_read(A_RLO, d);
    chk("midrst_result_late", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
